// File: rtl/fp_pkg.sv
// fp_pkg: shared rounding-mode type and default floating-point widths for the multiplier datapath
package fp_pkg;
  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3} round_mode_t;
  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_MANTISSA_WIDTH = 23;
  localparam int EXP_MAX = 2 ** FP_EXP_WIDTH - 1;
  localparam int PROD_WIDTH = 2 * (FP_MANTISSA_WIDTH + 1);
endpackage

// File: rtl/fp_round_decide.sv
// fp_round_decide: IEEE round-increment decision; in mode/sign/lsb/guard/sticky, out inc_o/inexact_o
module fp_round_decide
  import fp_pkg::*;
(
  input  round_mode_t mode_i,
  input  logic        sign_i,
  input  logic        lsb_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  output logic        inc_o,
  output logic        inexact_o
);
  always_comb begin
    inexact_o = guard_i | sticky_i;
    inc_o = mode_i == RNE ? guard_i & (sticky_i | lsb_i) :
            mode_i == RUP ? !sign_i & inexact_o :
            mode_i == RDN ? sign_i & inexact_o : 1'b0;
  end
endmodule

// File: rtl/fp_normalize_round_pipe.sv
// fp_normalize_round_pipe: 2-stage normalize/round/saturate of a significand product; valid_in/ready_in in, valid_out/ready_out out, sign/exp/mant plus overflow/underflow/inexact flags
module fp_normalize_round_pipe
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  input  logic                              sign_in,
  input  logic signed [EXP_WIDTH+1:0]       expoent_in,
  input  logic [2*(MANTISSA_WIDTH+1)-1:0]   result_in,
  input  logic [1:0]                        round_mode_in,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic                              sign_out,
  output logic [EXP_WIDTH-1:0]              normal_e_out,
  output logic [MANTISSA_WIDTH:0]           normal_m_out,
  output logic                              overflow_out,
  output logic                              underflow_out,
  output logic                              inexact_out
);
  localparam int M = MANTISSA_WIDTH;
  localparam int N = 2 * M + 1;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic signed [EW-1:0] EXP_TOP = EW'(2 ** EXP_WIDTH - 1);
  logic s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_g_q, s1_g_d, s1_s_q, s1_s_d, s1_zero_q, s1_zero_d;
  round_mode_t s1_mode_q, s1_mode_d;
  logic [M:0] s1_kept_q, s1_kept_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_ovf_q, s2_ovf_d, s2_unf_q, s2_unf_d, s2_inx_q, s2_inx_d;
  logic [EXP_WIDTH-1:0] s2_e_q, s2_e_d;
  logic [M:0] s2_m_q, s2_m_d;
  logic s2_load, s1_adv, in_xfer, hi, inc, rnd_inx, to_inf;
  logic [M+1:0] sum;
  logic [M:0] m_r;
  logic signed [EW-1:0] exp_r;
  assign s2_load  = !s2_valid_q | ready_out;
  assign ready_in = !s1_valid_q | s2_load;
  assign in_xfer  = valid_in & ready_in;
  assign s1_adv   = s1_valid_q & s2_load;
  assign hi       = result_in[N];
  always_comb begin
    s1_valid_d = ready_in ? valid_in : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mode_d  = s1_mode_q;
    s1_kept_d  = s1_kept_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    if (in_xfer) begin
      s1_sign_d = sign_in;
      s1_mode_d = round_mode_t'(round_mode_in);
      s1_kept_d = hi ? result_in[N:M+1] : result_in[N-1:M];
      s1_g_d    = hi ? result_in[M] : result_in[M-1];
      s1_s_d    = hi ? |result_in[M-1:0] : |result_in[M-2:0];
      s1_exp_d  = expoent_in + EW'(hi);
      s1_zero_d = result_in == '0;
    end
  end
  fp_round_decide u_round (
    .mode_i   (s1_mode_q),
    .sign_i   (s1_sign_q),
    .lsb_i    (s1_kept_q[0]),
    .guard_i  (s1_g_q),
    .sticky_i (s1_s_q),
    .inc_o    (inc),
    .inexact_o(rnd_inx)
  );
  always_comb begin
    sum    = {1'b0, s1_kept_q} + (M+2)'(inc);
    m_r    = sum[M+1] ? {1'b1, {M{1'b0}}} : sum[M:0];
    exp_r  = s1_exp_q + EW'(sum[M+1]);
    to_inf = s1_mode_q == RNE | (s1_mode_q == RUP & !s1_sign_q) | (s1_mode_q == RDN & s1_sign_q);
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_e_d     = s2_e_q;
    s2_m_d     = s2_m_q;
    s2_ovf_d   = s2_ovf_q;
    s2_unf_d   = s2_unf_q;
    s2_inx_d   = s2_inx_q;
    if (s1_adv) begin
      s2_sign_d = s1_sign_q;
      s2_e_d    = '0;
      s2_m_d    = '0;
      s2_ovf_d  = 1'b0;
      s2_unf_d  = 1'b0;
      s2_inx_d  = 1'b0;
      if (!s1_zero_q && exp_r >= EXP_TOP) begin
        s2_ovf_d = 1'b1;
        s2_inx_d = 1'b1;
        s2_e_d   = {{(EXP_WIDTH-1){1'b1}}, to_inf};
        s2_m_d   = {(M+1){!to_inf}};
      end else if (!s1_zero_q && (exp_r[EW-1] || exp_r == '0)) begin
        s2_unf_d = 1'b1;
        s2_inx_d = 1'b1;
      end else if (!s1_zero_q) begin
        s2_e_d   = exp_r[EXP_WIDTH-1:0];
        s2_m_d   = m_r;
        s2_inx_d = rnd_inx;
      end
    end
  end
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mode_q  <= RNE;
      s1_kept_q  <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_e_q     <= '0;
      s2_m_q     <= '0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_inx_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mode_q  <= s1_mode_d;
      s1_kept_q  <= s1_kept_d;
      s1_g_q     <= s1_g_d;
      s1_s_q     <= s1_s_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_e_q     <= s2_e_d;
      s2_m_q     <= s2_m_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
      s2_inx_q   <= s2_inx_d;
    end
  end
  assign valid_out     = s2_valid_q;
  assign sign_out      = s2_sign_q;
  assign normal_e_out  = s2_e_q;
  assign normal_m_out  = s2_m_q;
  assign overflow_out  = s2_ovf_q;
  assign underflow_out = s2_unf_q;
  assign inexact_out   = s2_inx_q;
endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// tb_fp_normalize_round_pipe: randomized and directed checks of the normalize/round pipeline against an arithmetic reference model
module tb_fp_normalize_round_pipe;
  import fp_pkg::*;
  typedef struct {
    bit              sign;
    int              ex;
    longint unsigned prod;
    int              mode;
  } stim_t;
  typedef struct {
    bit sign;
    int e;
    int m;
    bit ovf;
    bit unf;
    bit inx;
  } res_t;
  logic clk = 1'b0;
  logic rst;
  logic valid_in, ready_in, sign_in, valid_out, ready_out, sign_out;
  logic signed [FP_EXP_WIDTH+1:0] expoent_in;
  logic [PROD_WIDTH-1:0] result_in;
  logic [1:0] round_mode_in;
  logic [FP_EXP_WIDTH-1:0] normal_e_out;
  logic [FP_MANTISSA_WIDTH:0] normal_m_out;
  logic overflow_out, underflow_out, inexact_out;
  stim_t stim_q[$];
  res_t exp_q[$];
  stim_t cur;
  int checks = 0;
  int errors = 0;
  bit stalled_prev = 0;
  logic [36:0] held;
  always #5 clk = ~clk;
  fp_normalize_round_pipe dut (
    .clock_in     (clk),
    .reset_in     (rst),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .sign_in      (sign_in),
    .expoent_in   (expoent_in),
    .result_in    (result_in),
    .round_mode_in(round_mode_in),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .sign_out     (sign_out),
    .normal_e_out (normal_e_out),
    .normal_m_out (normal_m_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out),
    .inexact_out  (inexact_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [36:0] snap();
    return {valid_out, sign_out, normal_e_out, normal_m_out, overflow_out, underflow_out, inexact_out};
  endfunction
  function automatic res_t model(stim_t s);
    res_t r;
    longint unsigned kept, rem, half;
    bit g, st, inc, to_inf;
    int sh, e;
    sh   = s.prod[47] ? 24 : 23;
    kept = s.prod >> sh;
    rem  = s.prod & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    g    = rem >= half;
    st   = (rem & (half - 1)) != 0;
    e    = s.ex + (s.prod[47] ? 1 : 0);
    case (s.mode)
      0:       inc = g && (st || kept[0]);
      2:       inc = !s.sign && (g || st);
      3:       inc = s.sign && (g || st);
      default: inc = 0;
    endcase
    kept = kept + 64'(inc);
    if (kept == 64'd1 << 24) begin
      kept = 64'd1 << 23;
      e++;
    end
    r = '{s.sign, 0, 0, 0, 0, 0};
    if (s.prod == 0) return r;
    if (e >= EXP_MAX) begin
      to_inf = s.mode == 0 || (s.mode == 2 && !s.sign) || (s.mode == 3 && s.sign);
      r.ovf = 1;
      r.inx = 1;
      r.e = to_inf ? EXP_MAX : EXP_MAX - 1;
      r.m = to_inf ? 0 : 24'hFFFFFF;
    end else if (e <= 0) begin
      r.unf = 1;
      r.inx = 1;
    end else begin
      r.e = e;
      r.m = int'(kept);
      r.inx = g || st;
    end
    return r;
  endfunction
  function automatic stim_t mk(bit sign, int ex, longint unsigned prod, int mode);
    stim_t s;
    s.sign = sign;
    s.ex = ex;
    s.prod = prod;
    s.mode = mode;
    return s;
  endfunction
  function automatic stim_t rnd();
    longint unsigned a, b, p;
    a = 64'h800000 | 64'($urandom_range(0, 24'h7FFFFF));
    b = 64'h800000 | 64'($urandom_range(0, 24'h7FFFFF));
    p = a * b;
    if ($urandom_range(0, 7) == 0) p = (p & ~64'h7FFFFF) | 64'h400000;
    if ($urandom_range(0, 19) == 0) p = 0;
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)) - 20, p, int'($urandom_range(0, 3)));
  endfunction
  task automatic apply(input stim_t s);
    cur = s;
    sign_in = s.sign;
    expoent_in = 10'(s.ex);
    result_in = 48'(s.prod);
    round_mode_in = 2'(s.mode);
    valid_in = 1'b1;
  endtask
  task automatic step();
    bit acc;
    res_t r;
    @(negedge clk);
    if (stalled_prev) check("stall_hold", snap(), held);
    if (valid_out && ready_out) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("result", {sign_out, normal_e_out, normal_m_out, overflow_out, underflow_out, inexact_out},
              {r.sign, 8'(r.e), 24'(r.m), r.ovf, r.unf, r.inx});
      end
    end
    stalled_prev = valid_out && !ready_out;
    held = snap();
    acc = valid_in && ready_in;
    if (acc) exp_q.push_back(model(cur));
    @(posedge clk);
    #1;
    if (acc) valid_in = 1'b0;
  endtask
  task automatic run(input int pv, input int pr, input int budget);
    int n = 0;
    while ((stim_q.size() != 0 || valid_in || exp_q.size() != 0) && n < budget) begin
      ready_out = $urandom_range(0, 99) < pr;
      if (!valid_in && stim_q.size() != 0 && $urandom_range(0, 99) < pv) apply(stim_q.pop_front());
      step();
      n++;
    end
    check("drain_left", stim_q.size() + exp_q.size() + int'(valid_in), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b1;
    sign_in = 1'b0;
    expoent_in = '0;
    result_in = '0;
    round_mode_in = 2'd0;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_outputs", snap(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", ready_in, 1);
    apply(mk(0, 127, 48'h900000000000, 0));
    step();
    check("lat_cycle1", valid_out, 0);
    step();
    check("lat_cycle2", valid_out, 1);
    check("mul_e", normal_e_out, 128);
    check("mul_m", normal_m_out, 24'h900000);
    check("mul_flags", {overflow_out, underflow_out, inexact_out}, 0);
    step();
    stim_q.push_back(mk(0, 100, 48'h400000400000, 0));
    stim_q.push_back(mk(0, 100, 48'h400000C00000, 0));
    stim_q.push_back(mk(0, 100, 48'h7FFFFFC00000, 0));
    stim_q.push_back(mk(0, 254, 48'h800000000000, 0));
    stim_q.push_back(mk(0, 254, 48'h800000000000, 1));
    stim_q.push_back(mk(0, 254, 48'h800000000000, 3));
    stim_q.push_back(mk(1, 254, 48'h800000000000, 3));
    stim_q.push_back(mk(0, 0, 48'h400000000000, 0));
    stim_q.push_back(mk(1, 50, 48'h0, 2));
    run(100, 100, 100);
    ready_out = 1'b0;
    apply(rnd());
    step();
    apply(rnd());
    step();
    check("bp_ready_full", ready_in, 0);
    apply(rnd());
    step();
    step();
    check("bp_ready_held", ready_in, 0);
    check("bp_valid_held", valid_out, 1);
    run(100, 100, 50);
    for (int i = 0; i < 300; i++) stim_q.push_back(rnd());
    run(70, 70, 5000);
    ready_out = 1'b0;
    apply(rnd());
    step();
    apply(rnd());
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", valid_out, 0);
    check("midrst_outputs", snap(), 0);
    valid_in = 1'b0;
    exp_q.delete();
    stalled_prev = 0;
    ready_out = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", valid_out, 0);
    end
    for (int i = 0; i < 100; i++) stim_q.push_back(rnd());
    run(80, 60, 2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round_pipe.md
Name: fp_normalize_round_pipe

Overview:
- Two-stage pipelined normalizer and rounder for the floating-point multiplier datapath. Placed after the significand multiplier and exponent adder.
- Takes the raw 2*(MANTISSA_WIDTH+1)-bit significand product and a pre-biased, widened signed exponent. Normalizes, rounds per a selectable IEEE mode, and saturates to inf, max-finite or zero.
- Raises overflow, underflow and inexact flags.
- Valid/ready handshake on both sides; stalls without data loss.

Parameters:
- EXP_WIDTH, 8, biased exponent field width.
- MANTISSA_WIDTH, 23, stored fraction width (hidden bit excluded).

Ports:
- clock_in  input  1  pipeline clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  upstream operand valid.
- ready_in  output  1  block can accept an operand this cycle.
- sign_in  input  1  product sign.
- expoent_in  input  EXP_WIDTH+2  signed biased exponent (ea+eb-bias), may be negative or exceed 2^EXP_WIDTH-1.
- result_in  input  2*(MANTISSA_WIDTH+1)  unsigned significand product.
- round_mode_in  input  2  0=RNE, 1=RTZ, 2=RUP (+inf), 3=RDN (-inf).
- valid_out  output  1  result valid.
- ready_out  input  1  downstream accepts result.
- sign_out  output  1  result sign.
- normal_e_out  output  EXP_WIDTH  biased result exponent.
- normal_m_out  output  MANTISSA_WIDTH+1  significand including hidden bit; 0 for zero/inf.
- overflow_out  output  1  result overflowed.
- underflow_out  output  1  result flushed to zero from nonzero.
- inexact_out  output  1  precision lost.

Behaviour:
- Reset (async, any time, including mid-transfer): both stage valids clear; valid_out=0; all data/flag outputs 0; in-flight items discarded. ready_in=1 one cycle after reset deasserts.
- Transfer rules:
  - Input transfer when valid_in & ready_in; output transfer when valid_out & ready_out.
  - Stage advance: s2 loads when !s2_valid | ready_out. s1 loads when !s1_valid | s1 advances.
  - ready_in = !s1_valid | s2_can_load (combinational from ready_out).
  - Latency 2 cycles with ready_out=1; full throughput 1/cycle.
  - Outputs are registered and held stable while valid_out & !ready_out.
- Stage 1, normalize (N = 2*MANTISSA_WIDTH+1, product MSB index):
  - result_in[N]=1: kept=[N:MANTISSA_WIDTH+1], guard=[MANTISSA_WIDTH], sticky=OR[MANTISSA_WIDTH-1:0], exp=expoent_in+1.
  - Else: kept=[N-1:MANTISSA_WIDTH], guard=[MANTISSA_WIDTH-1], sticky=OR[MANTISSA_WIDTH-2:0], exp=expoent_in.
  - result_in==0 sets a zero tag. Register sign, mode, kept, guard, sticky, exp, zero tag.
- Stage 2, round increment:
  - RNE: g&(s|lsb). RTZ: 0. RUP: !sign&(g|s). RDN: sign&(g|s).
  - inexact = g|s.
  - If kept is all ones and incremented: m=1000..0 and exp+1.
- Stage 2, classification (after rounding, priority order):
  - zero tag: e=0, m=0, all flags 0, sign passes through.
  - exp >= 2^EXP_WIDTH-1: overflow_out=1, inexact_out=1. Result is inf (e all ones, m=0) for RNE, RUP&!sign, RDN&sign. Otherwise max-finite (e=2^EXP_WIDTH-2, m all ones).
  - exp <= 0: flush to zero (e=0, m=0), underflow_out=1, inexact_out=1. No subnormals produced.
  - Else: normal result, inexact per rounding.
- Exponent arithmetic in EXP_WIDTH+2 signed bits; no wrap possible for legal inputs.
- Simultaneous input and output transfer with both stages full: the pipeline shifts by one and order is preserved.

Decomposition:
- Package fp_pkg: round_mode_t enum (RNE, RTZ, RUP, RDN).
- Package fp_pkg: helper localparams EXP_MAX=2^EXP_WIDTH-1 and PROD_WIDTH=2*(MANTISSA_WIDTH+1).
- One combinational sub-module, fp_round_decide: inputs mode, sign, lsb, guard, sticky; outputs increment, inexact. Reusable by the planned adder.

Test Plan (defaults, ready_out=1 unless stated):
- 1.5*1.5: result_in=48'h900000000000, expoent_in=127, RNE -> two cycles later e=128, m=24'h900000, all flags 0.
- Tie rounding: kept lsb=0, g=1, s=0, RNE -> no increment, inexact=1. Same with lsb=1 -> m+1. All-ones kept with carry -> m=24'h800000, e+1.
- Overflow: expoent_in=254, result_in[47]=1:
  - RNE -> e=8'hFF, m=0, overflow=1.
  - RTZ -> e=8'hFE, m=24'hFFFFFF, overflow=1.
  - RDN with sign=0 -> max-finite.
- Underflow: expoent_in=0, result_in[47]=0, nonzero -> e=0, m=0, underflow=1, inexact=1. Also result_in=0 -> zero, all flags 0.
- Backpressure: issue 3 back-to-back items, hold ready_out=0 for 4 cycles.
  - ready_in drops once both stages are full.
  - Outputs stay stable while stalled.
  - After release, all 3 results emerge in order, with no loss or duplication.
- Reset mid-stream: assert reset_in asynchronously with 2 items in flight -> valid_out=0 immediately. No stale result appears after reset release.
